// File: rtl/lr_pkg.sv
// Shared fixed-point types and PLAN sigmoid constants for the logistic regression blocks.
// Constants are held in units of 1/32 so they scale to any FRAC_W >= 5.
package lr_pkg;

    localparam int LR_DATA_W = 16;
    localparam int LR_FRAC_W = 8;
    localparam int LR_CNT_W  = 16;

    typedef logic signed [LR_DATA_W-1:0] fix_t;

    localparam fix_t FIX_ONE  = fix_t'(1 << LR_FRAC_W);
    localparam fix_t FIX_HALF = fix_t'(1 << (LR_FRAC_W - 1));

    // PLAN breakpoints and offsets, value * 32
    localparam int PLAN_BP_HI_Q5    = 160;  // 5.0
    localparam int PLAN_BP_MID_Q5   = 76;   // 2.375
    localparam int PLAN_BP_LO_Q5    = 32;   // 1.0
    localparam int PLAN_OFF_MID_Q5  = 27;   // 0.84375
    localparam int PLAN_OFF_LO_Q5   = 20;   // 0.625
    localparam int PLAN_OFF_ZERO_Q5 = 16;   // 0.5
    localparam int PLAN_ONE_Q5      = 32;   // 1.0

    function automatic int plan_fix(input int q5, input int frac_w);
        return q5 << (frac_w - 5);
    endfunction

endpackage

// File: rtl/lr_sigmoid_plan.sv
// Combinational PLAN sigmoid: signed fixed-point z -> unsigned Q1.FRAC_W prob and label.
// Evaluated on |z| and mirrored as 1 - f(|z|) for negative inputs.
module lr_sigmoid_plan
    import lr_pkg::*;
#(
    parameter int DATA_W = LR_DATA_W,
    parameter int FRAC_W = LR_FRAC_W
) (
    input  logic signed [DATA_W-1:0] z,
    output logic        [FRAC_W:0]   prob,
    output logic                     label
);

    localparam int BP_HI    = plan_fix(PLAN_BP_HI_Q5, FRAC_W);
    localparam int BP_MID   = plan_fix(PLAN_BP_MID_Q5, FRAC_W);
    localparam int BP_LO    = plan_fix(PLAN_BP_LO_Q5, FRAC_W);
    localparam int OFF_MID  = plan_fix(PLAN_OFF_MID_Q5, FRAC_W);
    localparam int OFF_LO   = plan_fix(PLAN_OFF_LO_Q5, FRAC_W);
    localparam int OFF_ZERO = plan_fix(PLAN_OFF_ZERO_Q5, FRAC_W);
    localparam int ONE      = plan_fix(PLAN_ONE_Q5, FRAC_W);

    localparam logic [DATA_W-1:0] Z_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] A_MAX = {1'b0, {(DATA_W-1){1'b1}}};

    logic              neg;
    logic [DATA_W-1:0] a;
    logic [FRAC_W:0]   f;

    assign neg = z[DATA_W-1];

    // The most negative z has no positive twin; clamp it instead of wrapping.
    always_comb begin
        a = z;
        if (z == Z_MIN) begin
            a = A_MAX;
        end else if (neg) begin
            a = DATA_W'(-z);
        end
    end

    always_comb begin
        f = (FRAC_W+1)'(ONE);
        if (a >= DATA_W'(BP_HI)) begin
            f = (FRAC_W+1)'(ONE);
        end else if (a >= DATA_W'(BP_MID)) begin
            f = (FRAC_W+1)'(a >> 5) + (FRAC_W+1)'(OFF_MID);
        end else if (a >= DATA_W'(BP_LO)) begin
            f = (FRAC_W+1)'(a >> 3) + (FRAC_W+1)'(OFF_LO);
        end else begin
            f = (FRAC_W+1)'(a >> 2) + (FRAC_W+1)'(OFF_ZERO);
        end
    end

    assign prob  = neg ? (FRAC_W+1)'(ONE) - f : f;
    assign label = ~neg;

endmodule

// File: rtl/logistic_regression_inference.sv
// Three-stage fixed-point logistic regression inference: multiply, sum/saturate, sigmoid.
// A held output (out_valid & ~out_ready) freezes every stage; weights load independently.
module logistic_regression_inference
    import lr_pkg::*;
#(
    parameter int DATA_W = LR_DATA_W,
    parameter int FRAC_W = LR_FRAC_W,
    parameter int CNT_W  = LR_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wt_load,
    input  logic signed [DATA_W-1:0] wt_w1,
    input  logic signed [DATA_W-1:0] wt_w2,
    input  logic signed [DATA_W-1:0] wt_b,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] x1,
    input  logic signed [DATA_W-1:0] x2,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic        [FRAC_W:0]   prob,
    output logic                     label,
    output logic                     busy,
    output logic        [CNT_W-1:0]  out_count
);

    localparam int PW = 2 * DATA_W;
    localparam int SW = 2 * DATA_W + 2;

    localparam logic signed [SW-1:0] Z_MAX = {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SW-1:0] Z_MIN = {{(SW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [DATA_W-1:0] w1_q, w2_q, b_q;
    logic                     v1, v2, v3;
    logic signed [PW-1:0]     p1_q, p2_q;
    logic signed [DATA_W-1:0] b1_q;
    logic signed [DATA_W-1:0] z2_q;
    logic        [FRAC_W:0]   prob_q;
    logic                     label_q;
    logic        [CNT_W-1:0]  cnt_q;

    logic                     stall;
    logic signed [SW-1:0]     s_sum, s_shr;
    logic signed [DATA_W-1:0] z_sat;
    logic        [FRAC_W:0]   prob_c;
    logic                     label_c;

    assign stall     = v3 & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = v3;
    assign prob      = prob_q;
    assign label     = label_q;
    assign busy      = v1 | v2 | v3;
    assign out_count = cnt_q;

    always_comb begin
        s_sum = SW'(p1_q) + SW'(p2_q) + (SW'(b1_q) <<< FRAC_W);
        s_shr = s_sum >>> FRAC_W;
        z_sat = s_shr[DATA_W-1:0];
        if (s_shr > Z_MAX) begin
            z_sat = Z_MAX[DATA_W-1:0];
        end else if (s_shr < Z_MIN) begin
            z_sat = Z_MIN[DATA_W-1:0];
        end
    end

    lr_sigmoid_plan #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_sigmoid (
        .z     (z2_q),
        .prob  (prob_c),
        .label (label_c)
    );

    // Weights are not part of the pipeline, so they never see the stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w1_q <= '0;
            w2_q <= '0;
            b_q  <= '0;
        end else if (wt_load) begin
            w1_q <= wt_w1;
            w2_q <= wt_w2;
            b_q  <= wt_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            v3      <= 1'b0;
            p1_q    <= '0;
            p2_q    <= '0;
            b1_q    <= '0;
            z2_q    <= '0;
            prob_q  <= '0;
            label_q <= 1'b0;
        end else if (!stall) begin
            v1      <= in_valid;
            p1_q    <= PW'(w1_q) * PW'(x1);
            p2_q    <= PW'(w2_q) * PW'(x2);
            b1_q    <= b_q;
            v2      <= v1;
            z2_q    <= z_sat;
            v3      <= v2;
            prob_q  <= prob_c;
            label_q <= label_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (v3 && out_ready) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule
